// File: rtl/mem_req_serializer_pkg.sv
// Shared definitions for the memory request serializer: target codes, FSM states,
// beat counts and the FIFO entry layout.
package mem_req_serializer_pkg;

  // Request target codes
  localparam logic [1:0] TGT_SDRAM = 2'd0;
  localparam logic [1:0] TGT_FLASH = 2'd1;
  localparam logic [1:0] TGT_ROM   = 2'd2;
  localparam logic [1:0] TGT_ILL   = 2'd3;

  // Beats per request on the multi-beat channels
  localparam int unsigned SDRAM_BEATS = 2;
  localparam int unsigned ROM_BEATS   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSLo,
    StSHi,
    StFl,
    StRom
  } state_e;

  typedef struct packed {
    logic [1:0] target;
    logic [7:0] data;
  } req_t;

  // ROM beat k carries bits [2k+1:2k] zero-extended to three bits
  function automatic logic [2:0] rom_chunk(input logic [7:0] d, input logic [1:0] k);
    return {1'b0, d[{k, 1'b0} +: 2]};
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// DEPTH-entry synchronous FIFO of {target, data} request words with a synchronous flush.
// Push is ignored when full and pop when empty; there is no full-bypass.
module mem_req_fifo
  import mem_req_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  req_t wdata_i,
  input  logic pop_i,
  output req_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CNT_W = PTR_W + 1;

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Occupancy next-state from the push/pop pair
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy qualifies every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_req_serializer.sv
// Buffers byte requests and serializes each into SDRAM (2 nibbles), flash (1 byte) or
// ROM (4 x 3-bit) beats, one request at a time in FIFO order.
// Optional MEM_REQ_TGT_CHECK_EN: target 3 is dropped and flagged on err; otherwise it is
// sent as a flash beat and err stays 0.
module mem_req_serializer
  import mem_req_serializer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_target,
  input  logic [7:0] req_data,
  output logic       sdram_valid,
  output logic [3:0] sdram_data_o,
  input  logic       sdram_ready,
  output logic       flash_valid,
  output logic [7:0] flash_data_o,
  input  logic       flash_ready,
  output logic       rom_valid,
  output logic [2:0] rom_data_o,
  input  logic       rom_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] ROM_LAST = 2'(ROM_BEATS - 1);

  state_e     state_q, state_d;
  logic [1:0] k_q, k_d;
  req_t       head;
  logic       full, empty, push, pop;

  assign req_ready = !full && !reset;
  assign push      = req_valid && req_ready;
  assign busy      = !empty || (state_q != StIdle);

  mem_req_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({req_target, req_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef MEM_REQ_TGT_CHECK_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next state, ROM beat counter and pop on the final beat's fire
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pop     = 1'b0;
`ifdef MEM_REQ_TGT_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          k_d = '0;
          if (head.target == TGT_SDRAM) begin
            state_d = StSLo;
          end else if (head.target == TGT_ROM) begin
            state_d = StRom;
`ifdef MEM_REQ_TGT_CHECK_EN
          end else if (head.target == TGT_ILL) begin
            pop   = 1'b1;
            err_d = 1'b1;
`endif
          end else begin
            state_d = StFl;
          end
        end
      end
      StSLo: if (sdram_ready) state_d = StSHi;
      StSHi: begin
        if (sdram_ready) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      StFl: begin
        if (flash_ready) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      StRom: begin
        if (rom_ready) begin
          if (k_q == ROM_LAST) begin
            pop     = 1'b1;
            state_d = StIdle;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat presentation decoded from the registered state; head is stable until pop
  always_comb begin
    sdram_valid  = 1'b0;
    sdram_data_o = '0;
    flash_valid  = 1'b0;
    flash_data_o = '0;
    rom_valid    = 1'b0;
    rom_data_o   = '0;
    unique case (state_q)
      StSLo: begin
        sdram_valid  = 1'b1;
        sdram_data_o = head.data[3:0];
      end
      StSHi: begin
        sdram_valid  = 1'b1;
        sdram_data_o = head.data[7:4];
      end
      StFl: begin
        flash_valid  = 1'b1;
        flash_data_o = head.data;
      end
      StRom: begin
        rom_valid  = 1'b1;
        rom_data_o = rom_chunk(head.data, k_q);
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
`ifdef MEM_REQ_TGT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
`ifdef MEM_REQ_TGT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
